spi_frame_arbiter: RTL
======================

SPI_FRAME_ARBITER -- requirements
Module: spi_frame_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CLKS, default 4, giving the idle clk cycles between frames with spi_start low and SS high.
REQ-002 The block SHALL have parameter WORD_W, fixed at 16, giving the frame width of two bytes sent MSB byte first.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port req0 / req1, input, 1 bit each: requester channel asserts and holds high until its ack pulse.
REQ-006 The block SHALL have port word0 / word1, input, 16 bits each: channel frame, held stable while the matching req is high.
REQ-007 The block SHALL have port ack0 / ack1, output, 1 bit each: one-cycle pulse when that channel's frame has completed.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port spi_start, output, 1 bit: start strobe to the SPI byte transmitter.
REQ-010 The block SHALL have port spi_data, output, 8 bits: byte presented to the transmitter.
REQ-011 The block SHALL have port spi_ss, input, 1 bit: transmitter SS, low while a byte is shifting and high when idle.

Function
REQ-012 The block SHALL use FSM states IDLE, SEND, WAIT_LOW, WAIT_HIGH and GAP.
REQ-013 In IDLE with any req high, the block SHALL on the next edge grant one channel, latch its word into a 16-bit shadow register, clear byte_idx to 0 and go to SEND.
REQ-014 Arbitration SHALL be round-robin: if only one req is high, that channel is granted; if both are high, the channel not granted last wins.
REQ-015 After reset, channel 0 SHALL win the first simultaneous request, with last_grant reset to 1.
REQ-016 In SEND, the block SHALL drive spi_start=1 for exactly one cycle with spi_data = shadow[15:8] when byte_idx=0, or shadow[7:0] when byte_idx=1, then go to WAIT_LOW.
REQ-017 spi_data SHALL hold its value from SEND until the next SEND.
REQ-018 In WAIT_LOW, the block SHALL wait for spi_ss==0, then go to WAIT_HIGH.
REQ-019 In WAIT_HIGH, the block SHALL wait for spi_ss==1.
REQ-020 On spi_ss==1 in WAIT_HIGH with byte_idx=0, the block SHALL set byte_idx=1 and go to SEND.
REQ-021 On spi_ss==1 in WAIT_HIGH with byte_idx=1, the block SHALL load the gap counter with 0 and go to GAP.
REQ-022 In GAP, the block SHALL increment the counter each cycle.
REQ-023 When the gap counter equals GAP_CLKS-1, the block SHALL pulse ack for the granted channel, update last_grant and return to IDLE.
REQ-024 The latency from req sampled high in IDLE to spi_start high SHALL be 1 cycle.
REQ-025 The latency from the final SS rise to ack SHALL be GAP_CLKS cycles.
REQ-026 A new frame SHALL NOT start in the same cycle as an ack; the earliest next grant is the cycle after ack.
REQ-027 A requester holding req high through its own ack SHALL still lose to the other channel if that channel is pending.
REQ-028 A req that drops mid-frame SHALL be ignored: the frame completes and ack still pulses.
REQ-029 word changes after grant SHALL have no effect on the frame in progress.
REQ-030 spi_start SHALL never be high outside SEND, and never for two consecutive cycles.
REQ-031 Exactly one ack SHALL be high in any cycle, or none.
REQ-032 spi_ss already low on entry to WAIT_LOW SHALL pass straight through.
REQ-033 The block SHALL have no timeout: a stuck SS holds the FSM in WAIT_LOW or WAIT_HIGH until reset.

Reset
REQ-034 On reset high, immediately and independent of clk, the block SHALL force state=IDLE, spi_start=0, spi_data=8'h00, ack0=ack1=0, busy=0, byte_idx=0, gap counter=0 and last_grant=1.
REQ-035 A reset asserted mid-frame SHALL abandon the frame, produce no ack and not retry it; arbitration resumes normally after reset drops.

Verification
REQ-036 Single request: req0=1 with word0=16'hA55A -> spi_start pulses twice, with spi_data 8'hA5 then 8'h5A, one ack0 pulse 4 cycles after the second SS rise, and busy low afterwards.
REQ-037 Simultaneous requests after reset: req0=req1=1, word1=16'h1234 -> channel 0 is served first, then bytes 8'h12 and 8'h34, then ack1, so the order is ack0 then ack1.
REQ-038 Fairness: req0 held high continuously with req1 pulsed high -> grants alternate 0,1,0,1 with no channel served twice in a row while the other is pending.
REQ-039 Data change after grant: word0 changed to 16'hFFFF one cycle after grant -> the transmitted bytes are still those of the original word.
REQ-040 Reset mid-frame: reset asserted in WAIT_HIGH of byte 0 -> all outputs are at reset values immediately and no ack appears; after release, a pending req is restarted from byte 0.
REQ-041 Stuck SS: spi_ss held high after spi_start -> the FSM stays in WAIT_LOW, busy=1 and spi_start=0 for at least 100 cycles.

Source files
------------

// File: rtl/spi_frame_arbiter.sv
// Two-channel round-robin arbiter that sends each granted 16-bit word as two
// SPI bytes (MSB byte first), then idles GAP_CLKS cycles before acknowledging.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no frame in flight, arbitrate between req0/req1
// SEND      | spi_start high for one cycle, spi_data holds current byte
// WAIT_LOW  | waiting for the transmitter to pull SS low
// WAIT_HIGH | waiting for SS to return high (byte finished)
// GAP       | inter-frame gap count, ack on the last count
module spi_frame_arbiter #(
   parameter int GAP_CLKS = 4,
   parameter int WORD_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [WORD_W-1:0] word0,
   input  logic [WORD_W-1:0] word1,
   output logic              ack0,
   output logic              ack1,
   output logic              busy,
   output logic              spi_start,
   output logic [7:0]        spi_data,
   input  logic              spi_ss
);

   localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_LOW,
      WAIT_HIGH,
      GAP
   } state_t;

   state_t            state;
   logic              byte_idx;
   logic              cur_ch;
   logic              last_grant;
   logic [GAP_W-1:0]  gap_cnt;
   logic [7:0]        shadow_lo;

   logic              grant_ch;
   logic [WORD_W-1:0] grant_word;

   // Round-robin: on a tie the channel not served last wins.
   always_comb begin
      grant_ch = 1'b0;
      if (req0 && req1) begin
         grant_ch = ~last_grant;
      end else if (req1) begin
         grant_ch = 1'b1;
      end
   end

   assign grant_word = grant_ch ? word1 : word0;

   // The high byte goes straight to spi_data at grant; only the low byte
   // needs to be kept for the second SEND.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_idx   <= 1'b0;
         cur_ch     <= 1'b0;
         last_grant <= 1'b1;
         gap_cnt    <= '0;
         shadow_lo  <= 8'h00;
         spi_start  <= 1'b0;
         spi_data   <= 8'h00;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         spi_start <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  cur_ch    <= grant_ch;
                  shadow_lo <= grant_word[7:0];
                  spi_data  <= grant_word[WORD_W-1 -: 8];
                  byte_idx  <= 1'b0;
                  spi_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!spi_ss) begin
                  state <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (spi_ss) begin
                  if (!byte_idx) begin
                     byte_idx  <= 1'b1;
                     spi_data  <= shadow_lo;
                     spi_start <= 1'b1;
                     state     <= SEND;
                  end else begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  ack0       <= ~cur_ch;
                  ack1       <= cur_ch;
                  last_grant <= cur_ch;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
